// File: rtl/round_timer_pkg.sv
// Shared definitions for the round timer: FSM state encoding and prescaler sizing helper.
package round_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_PAUSED = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Smallest counter width able to hold 0..div-1 (never narrower than one bit).
    function automatic int div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/round_timer_tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while enabled and emits a one-cycle tick on the last count.
// clr restarts the count from zero and overrides en; a disabled counter simply holds its value.
module tick_prescaler
    import round_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int DIV_W    = div_width(TICK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;

    // Next count: clear wins, otherwise advance and wrap on the last count while enabled.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    assign tick = en && !clr && (presc_q == LAST);

    // Prescaler count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/round_timer.sv
// Game-round timer: counts prescaled ticks up to a limit or down from it to zero,
// with pause/resume, abort, a held done flag and a one-cycle expiry pulse.
module round_timer
    import round_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int VALUE_W  = 8,
    parameter int DIV_W    = div_width(TICK_DIV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               count_down,
    input  logic [VALUE_W-1:0] limit,
    input  logic               pause,
    input  logic               abort,
    output logic [VALUE_W-1:0] value,
    output logic               running,
    output logic               paused,
    output logic               done,
    output logic               expired
);

    state_t             state_q,   state_d;
    logic [VALUE_W-1:0] value_q,   value_d;
    logic [VALUE_W-1:0] limit_q,   limit_d;
    logic               mode_q,    mode_d;
    logic               expired_q, expired_d;

    logic               tick;
    logic               presc_en;
    logic               active;
    logic               at_target;
    logic [VALUE_W-1:0] target;
    logic [VALUE_W-1:0] next_value;

    assign target     = mode_q ? '0 : limit_q;
    assign at_target  = (value_q == target);
    assign next_value = mode_q ? value_q - 1'b1 : value_q + 1'b1;
    assign active     = (state_q == ST_RUN) || (state_q == ST_PAUSED);

    // Time only advances in cycles where the timer is active, not held by pause, and not
    // being reloaded or aborted. Counting the release cycle out of PAUSED makes a pause of
    // N cycles delay every later tick by exactly N cycles.
    assign presc_en = active && !pause && !abort && !start && !at_target;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (presc_en),
        .tick (tick)
    );

    // FSM and value update with priority start > abort > pause > tick.
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        expired_d = 1'b0;
        if (start) begin
            mode_d  = count_down;
            limit_d = limit;
            value_d = count_down ? limit : '0;
            state_d = ST_RUN;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (at_target) begin
                        state_d   = ST_DONE;
                        expired_d = 1'b1;
                    end else if (tick) begin
                        value_d = next_value;
                        if (next_value == target) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                        if (tick) begin
                            value_d = next_value;
                            if (next_value == target) begin
                                state_d   = ST_DONE;
                                expired_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, count, captured mode/limit and expiry pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            value_q   <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

    assign value   = value_q;
    assign running = (state_q == ST_RUN);
    assign paused  = (state_q == ST_PAUSED);
    assign done    = (state_q == ST_DONE);
    assign expired = expired_q;

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer with TICK_DIV=4, VALUE_W=8: a cycle-level reference model
// built on "elapsed active cycles" is compared every cycle, plus hand-computed literal checks.
module tb_round_timer;

    localparam int TICK_DIV = 4;
    localparam int VALUE_W  = 8;
    localparam int DIV_W    = 2;

    localparam int P_IDLE   = 0;
    localparam int P_RUN    = 1;
    localparam int P_PAUSED = 2;
    localparam int P_DONE   = 3;

    logic               clk;
    logic               rst;
    logic               start;
    logic               count_down;
    logic [VALUE_W-1:0] limit;
    logic               pause;
    logic               abort;
    logic [VALUE_W-1:0] value;
    logic               running;
    logic               paused;
    logic               done;
    logic               expired;

    int n_compared   = 0;
    int n_mismatched = 0;

    int m_phase   = P_IDLE;
    int m_elapsed = 0;
    int m_limit   = 0;
    bit m_down    = 1'b0;
    bit m_expired = 1'b0;

    round_timer #(
        .TICK_DIV (TICK_DIV),
        .VALUE_W  (VALUE_W),
        .DIV_W    (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .count_down (count_down),
        .limit      (limit),
        .pause      (pause),
        .abort      (abort),
        .value      (value),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .expired    (expired)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_ticks();
        return m_elapsed / TICK_DIV;
    endfunction

    function automatic int model_value();
        return m_down ? (m_limit - model_ticks()) : model_ticks();
    endfunction

    // Reference model: value is derived from the number of un-paused active cycles since start.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase   = P_IDLE;
                m_elapsed = 0;
                m_limit   = 0;
                m_down    = 1'b0;
                m_expired = 1'b0;
            end else begin
                m_expired = 1'b0;
                if (start) begin
                    m_limit   = int'(limit);
                    m_down    = count_down;
                    m_elapsed = 0;
                    m_phase   = P_RUN;
                end else if (abort && m_phase != P_IDLE) begin
                    m_phase = P_IDLE;
                end else if (m_phase == P_RUN && model_ticks() == m_limit) begin
                    m_phase   = P_DONE;
                    m_expired = 1'b1;
                end else if ((m_phase == P_RUN || m_phase == P_PAUSED) && !pause) begin
                    m_elapsed = m_elapsed + 1;
                    if (model_ticks() == m_limit) begin
                        m_phase   = P_DONE;
                        m_expired = 1'b1;
                    end else begin
                        m_phase = P_RUN;
                    end
                end else if (m_phase == P_RUN && pause) begin
                    m_phase = P_PAUSED;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_compared++;
                if (int'(value) != model_value() || running != (m_phase == P_RUN) ||
                    paused != (m_phase == P_PAUSED) || done != (m_phase == P_DONE) ||
                    expired != m_expired) begin
                    n_mismatched++;
                    $display("[TB] FAIL model @%0t: got value=%0d run=%0b pause=%0b done=%0b exp=%0b, required value=%0d run=%0b pause=%0b done=%0b exp=%0b",
                             $time, value, running, paused, done, expired, model_value(),
                             m_phase == P_RUN, m_phase == P_PAUSED, m_phase == P_DONE, m_expired);
                end
            end
        end
    end

    // Drive one cycle of inputs starting at a falling edge, return at the next falling edge.
    task automatic applyStimulus(input bit s, input bit cd, input logic [VALUE_W-1:0] lim,
                                 input bit p, input bit a);
        start      = s;
        count_down = cd;
        limit      = lim;
        pause      = p;
        abort      = a;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Hand-computed expectation for all outputs.
    task automatic checkOutput(input string name, input int exp_value, input bit exp_run,
                               input bit exp_pause, input bit exp_done, input bit exp_exp);
        n_compared++;
        if (int'(value) != exp_value || running != exp_run || paused != exp_pause ||
            done != exp_done || expired != exp_exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got value=%0d run=%0b pause=%0b done=%0b exp=%0b, required value=%0d run=%0b pause=%0b done=%0b exp=%0b",
                     name, value, running, paused, done, expired,
                     exp_value, exp_run, exp_pause, exp_done, exp_exp);
        end
    endtask

    // Directed scenarios.
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        count_down = 1'b0;
        limit      = '0;
        pause      = 1'b0;
        abort      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_hold", 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_idle", 0, 0, 0, 0, 0);

        $display("[TB] down count from 3");
        applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        checkOutput("down_load", 3, 1, 0, 0, 0);
        idle(3);
        checkOutput("down_pre_tick", 3, 1, 0, 0, 0);
        idle(1);
        checkOutput("down_tick1", 2, 1, 0, 0, 0);
        idle(4);
        checkOutput("down_tick2", 1, 1, 0, 0, 0);
        idle(4);
        checkOutput("down_end", 0, 0, 0, 1, 1);
        idle(1);
        checkOutput("down_expired_once", 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("done_ignores_pause", 0, 0, 0, 1, 0);

        $display("[TB] up count to 2 with a 5-cycle pause");
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        checkOutput("up_load", 0, 1, 0, 0, 0);
        idle(2);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("up_paused", 0, 0, 1, 0, 0);
        repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("up_still_paused", 0, 0, 1, 0, 0);
        idle(1);
        checkOutput("up_resumed", 0, 1, 0, 0, 0);
        idle(1);
        checkOutput("up_tick1_delayed", 1, 1, 0, 0, 0);
        idle(3);
        checkOutput("up_pre_end", 1, 1, 0, 0, 0);
        idle(1);
        checkOutput("up_end", 2, 0, 0, 1, 1);
        idle(1);

        $display("[TB] zero limit in both modes");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("zero_up_run", 0, 1, 0, 0, 0);
        idle(1);
        checkOutput("zero_up_done", 0, 0, 0, 1, 1);
        idle(1);
        checkOutput("zero_up_hold", 0, 0, 0, 1, 0);
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        checkOutput("zero_down_run", 0, 1, 0, 0, 0);
        idle(1);
        checkOutput("zero_down_done", 0, 0, 0, 1, 1);
        idle(1);

        $display("[TB] abort mid-count and from pause");
        applyStimulus(1'b1, 1'b1, 8'd10, 1'b0, 1'b0);
        checkOutput("abort_load", 10, 1, 0, 0, 0);
        idle(20);
        checkOutput("abort_pre", 5, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("abort_idle", 5, 0, 0, 0, 0);
        idle(5);
        checkOutput("abort_holds", 5, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 8'd10, 1'b0, 1'b0);
        checkOutput("abort_reload", 10, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("abort_from_pause", 10, 0, 0, 0, 0);

        $display("[TB] start while paused");
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
        checkOutput("start_in_pause", 0, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("repause", 0, 0, 1, 0, 0);
        idle(1);

        $display("[TB] start coincident with terminal tick");
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
        checkOutput("coincide_reload", 0, 1, 0, 0, 0);
        idle(3);
        checkOutput("coincide_pre_end", 0, 1, 0, 0, 0);
        idle(1);
        checkOutput("coincide_end", 1, 0, 0, 1, 1);
        idle(1);

        $display("[TB] asynchronous reset mid-count and during expiry");
        applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        idle(5);
        checkOutput("rst_pre", 2, 1, 0, 0, 0);
        rst = 1'b1;
        #2;
        checkOutput("rst_mid_count", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_after_count", 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
        idle(4);
        checkOutput("rst_exp_pre", 0, 0, 0, 1, 1);
        rst = 1'b1;
        #2;
        checkOutput("rst_cuts_expired", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_after_expired", 0, 0, 0, 0, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
